// File: rtl/rpn_stack_calculator_if.sv
// ---------------------------------------------------------------------------
// rpn_stack_calculator_if
//
// Bundles the command and display signals of the RPN stack calculator.
//
//   master : drives Clear, Enter, IsOp, DataIn; observes the display path
//   slave  : the calculator itself; receives commands and drives ToDisplay,
//            Flags ({N,Z,C,V}), Count, Error and CurrentState
//
// Parameters WIDTH and DEPTH must match the calculator instance.
// ---------------------------------------------------------------------------
interface rpn_stack_calculator_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             Clear;
    logic             Enter;
    logic             IsOp;
    logic [WIDTH-1:0] DataIn;
    logic [WIDTH-1:0] ToDisplay;
    logic [3:0]       Flags;
    logic [CW-1:0]    Count;
    logic             Error;
    logic [1:0]       CurrentState;

    modport master (
        output Clear, Enter, IsOp, DataIn,
        input  ToDisplay, Flags, Count, Error, CurrentState
    );

    modport slave (
        input  Clear, Enter, IsOp, DataIn,
        output ToDisplay, Flags, Count, Error, CurrentState
    );
endinterface

// File: rtl/rpn_stack_calculator.sv
// ---------------------------------------------------------------------------
// rpn_stack_calculator
//
// Reverse-Polish calculator with a DEPTH-entry operand stack of WIDTH-bit
// values, {N,Z,C,V} status flags and a sticky error indication.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : rpn_stack_calculator_if.slave
//            Clear        - synchronous clear, wins over a coincident command
//            Enter        - level input; each rising edge is one command
//            IsOp/DataIn  - captured with the Enter edge (opcode or operand)
//            ToDisplay    - top of stack, 0 when empty
//            Flags        - {N,Z,C,V} of the last ADD/SUB/AND/OR/MUL
//            Count        - occupied stack entries
//            Error        - sticky overflow/underflow/illegal-opcode flag
//            CurrentState - 0 IDLE, 1 PUSH, 2 EXEC, 3 ERROR
//
// Build option: define RPN_MUL_EN to make opcode 7 a signed multiply;
// without it opcode 7 is illegal.
//
// Command pipeline: the Enter edge is latched at edge k, the FSM leaves IDLE
// at edge k+1 and the stack update lands at edge k+2.
// ---------------------------------------------------------------------------
module rpn_stack_calculator #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    rpn_stack_calculator_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PUSH  = 2'd1,
        EXEC  = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             enter_q, enter_d;
    logic             cmd_q, cmd_d;
    logic             is_op_q, is_op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [3:0]       flags_q, flags_d;
    logic             error_q, error_d;

    // Entry count_q-1 is the top (B), count_q-2 the one below it (A).
    logic [IW-1:0]    top_idx, next_idx, push_idx;
    logic [WIDTH-1:0] a_val, b_val;
    logic [WIDTH:0]   sum_ext, diff_ext;

    logic             bin_op;
    logic [WIDTH-1:0] bin_res;
    logic [3:0]       bin_flags;
    logic             fault;

    assign top_idx  = IW'(count_q - CW'(1));
    assign next_idx = IW'(count_q - CW'(2));
    assign push_idx = IW'(count_q);
    assign a_val    = stack_q[next_idx];
    assign b_val    = stack_q[top_idx];
    assign sum_ext  = {1'b0, a_val} + {1'b0, b_val};
    // The extra MSB of the difference is the unsigned borrow (A < B).
    assign diff_ext = {1'b0, a_val} - {1'b0, b_val};

`ifdef RPN_MUL_EN
    logic signed [2*WIDTH-1:0] prod;
    logic                      mul_ovf;
    assign prod = $signed({{WIDTH{a_val[WIDTH-1]}}, a_val}) *
                  $signed({{WIDTH{b_val[WIDTH-1]}}, b_val});
    // The product fits only if all bits above the result sign are copies of it.
    assign mul_ovf = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));
`endif

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                            input logic c, input logic v);
        return {r[WIDTH-1], (r == '0), c, v};
    endfunction

    assign bus.ToDisplay    = (count_q == '0) ? '0 : stack_q[top_idx];
    assign bus.Flags        = flags_q;
    assign bus.Count        = count_q;
    assign bus.Error        = error_q;
    assign bus.CurrentState = state_q;

    always_comb begin
        state_d   = state_q;
        enter_d   = bus.Enter;
        cmd_d     = 1'b0;
        is_op_d   = is_op_q;
        data_d    = data_q;
        stack_d   = stack_q;
        count_d   = count_q;
        flags_d   = flags_q;
        error_d   = error_q;
        bin_op    = 1'b0;
        bin_res   = '0;
        bin_flags = '0;
        fault     = 1'b0;

        // A new edge is latched only if no command is still waiting for IDLE;
        // otherwise it would overwrite the operand about to be used.
        if (bus.Enter && !enter_q && !cmd_q && state_q != ERROR) begin
            cmd_d   = 1'b1;
            is_op_d = bus.IsOp;
            data_d  = bus.DataIn;
        end

        case (state_q)
            IDLE: begin
                if (cmd_q) state_d = is_op_q ? EXEC : PUSH;
            end
            PUSH: begin
                state_d = IDLE;
                if (count_q == FULL) begin
                    fault = 1'b1;
                end else begin
                    stack_d[push_idx] = data_q;
                    count_d           = count_q + CW'(1);
                end
            end
            EXEC: begin
                state_d = IDLE;
                case (data_q[2:0])
                    3'd0: begin
                        bin_op    = 1'b1;
                        bin_res   = sum_ext[WIDTH-1:0];
                        bin_flags = mk_flags(bin_res, sum_ext[WIDTH],
                                             (a_val[WIDTH-1] == b_val[WIDTH-1]) &&
                                             (bin_res[WIDTH-1] != a_val[WIDTH-1]));
                    end
                    3'd1: begin
                        bin_op    = 1'b1;
                        bin_res   = diff_ext[WIDTH-1:0];
                        bin_flags = mk_flags(bin_res, diff_ext[WIDTH],
                                             (a_val[WIDTH-1] != b_val[WIDTH-1]) &&
                                             (bin_res[WIDTH-1] != a_val[WIDTH-1]));
                    end
                    3'd2: begin
                        bin_op    = 1'b1;
                        bin_res   = a_val & b_val;
                        bin_flags = mk_flags(bin_res, 1'b0, 1'b0);
                    end
                    3'd3: begin
                        bin_op    = 1'b1;
                        bin_res   = a_val | b_val;
                        bin_flags = mk_flags(bin_res, 1'b0, 1'b0);
                    end
                    3'd4: begin
                        if (count_q == '0 || count_q == FULL) begin
                            fault = 1'b1;
                        end else begin
                            stack_d[push_idx] = b_val;
                            count_d           = count_q + CW'(1);
                        end
                    end
                    3'd5: begin
                        if (count_q < CW'(2)) begin
                            fault = 1'b1;
                        end else begin
                            stack_d[top_idx]  = a_val;
                            stack_d[next_idx] = b_val;
                        end
                    end
                    3'd6: begin
                        if (count_q == '0) fault = 1'b1;
                        else               count_d = count_q - CW'(1);
                    end
                    default: begin
`ifdef RPN_MUL_EN
                        bin_op    = 1'b1;
                        bin_res   = prod[WIDTH-1:0];
                        bin_flags = mk_flags(bin_res, 1'b0, mul_ovf);
`else
                        fault = 1'b1;
`endif
                    end
                endcase

                if (bin_op) begin
                    if (count_q < CW'(2)) begin
                        fault = 1'b1;
                    end else begin
                        stack_d[next_idx] = bin_res;
                        count_d           = count_q - CW'(1);
                        flags_d           = bin_flags;
                    end
                end
            end
            default: begin
                state_d = ERROR;
            end
        endcase

        if (fault) begin
            state_d = ERROR;
            error_d = 1'b1;
        end

        // Clear drops any pending command but lets enter_q track Enter so a
        // held Enter does not fire again once Clear is released.
        if (bus.Clear) begin
            cmd_d   = 1'b0;
            state_d = IDLE;
            count_d = '0;
            flags_d = '0;
            error_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            enter_q <= 1'b0;
            cmd_q   <= 1'b0;
            is_op_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
            flags_q <= '0;
            error_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
        end else begin
            state_q <= state_d;
            enter_q <= enter_d;
            cmd_q   <= cmd_d;
            is_op_q <= is_op_d;
            data_q  <= data_d;
            count_q <= count_d;
            flags_q <= flags_d;
            error_q <= error_d;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
        end
    end
endmodule

// File: tb/tb_rpn_stack_calculator.sv
// ---------------------------------------------------------------------------
// tb_rpn_stack_calculator
//
// Drives directed and random command sequences into rpn_stack_calculator and
// compares every observable output against a queue-based RPN model.
// Define RPN_MUL_EN identically for bench and design.
// ---------------------------------------------------------------------------
module tb_rpn_stack_calculator;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    rpn_stack_calculator_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    rpn_stack_calculator #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: the stack is a queue whose back is the top.
    logic [15:0] m_stack[$];
    logic [3:0]  m_flags;
    bit          m_err;

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit out_of_range(input int v);
        return (v > 32767) || (v < -32768);
    endfunction

    task automatic model_reset();
        m_stack.delete();
        m_flags = 4'h0;
        m_err   = 1'b0;
    endtask

    task automatic model_apply(input bit is_op, input logic [15:0] data);
        logic [15:0] a, b, r;
        int          sa, sb, sr;
        int unsigned ua, ub, ur;
        bit          c, v;
        logic [2:0]  op;
        if (m_err) return;
        if (!is_op) begin
            if (m_stack.size() == DEPTH) m_err = 1'b1;
            else                         m_stack.push_back(data);
            return;
        end
        op = data[2:0];
        case (op)
            3'd4: begin
                if (m_stack.size() == 0 || m_stack.size() == DEPTH) m_err = 1'b1;
                else m_stack.push_back(m_stack[$]);
                return;
            end
            3'd5: begin
                if (m_stack.size() < 2) begin
                    m_err = 1'b1;
                end else begin
                    b = m_stack.pop_back();
                    a = m_stack.pop_back();
                    m_stack.push_back(b);
                    m_stack.push_back(a);
                end
                return;
            end
            3'd6: begin
                if (m_stack.size() == 0) m_err = 1'b1;
                else                     void'(m_stack.pop_back());
                return;
            end
            default: ;
        endcase
`ifndef RPN_MUL_EN
        if (op == 3'd7) begin
            m_err = 1'b1;
            return;
        end
`endif
        if (m_stack.size() < 2) begin
            m_err = 1'b1;
            return;
        end
        b  = m_stack.pop_back();
        a  = m_stack.pop_back();
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            3'd0: begin
                ur = ua + ub;
                r  = ur[15:0];
                c  = (ur > 65535);
                v  = out_of_range(sa + sb);
            end
            3'd1: begin
                r = a - b;
                c = (ua < ub);
                v = out_of_range(sa - sb);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            default: begin
                sr = sa * sb;
                r  = sr[15:0];
                v  = out_of_range(sr);
            end
        endcase
        m_stack.push_back(r);
        m_flags = {r[15], (r == 16'h0), c, v};
    endtask

    task automatic check_all(input string tag);
        logic [15:0] exp_tod;
        exp_tod = (m_stack.size() == 0) ? 16'h0 : m_stack[$];
        checkOutput({tag, "_tod"},   32'(bus.ToDisplay),    32'(exp_tod));
        checkOutput({tag, "_count"}, 32'(bus.Count),        32'(m_stack.size()));
        checkOutput({tag, "_flags"}, 32'(bus.Flags),        32'(m_flags));
        checkOutput({tag, "_error"}, 32'(bus.Error),        32'(m_err));
        checkOutput({tag, "_state"}, 32'(bus.CurrentState), m_err ? 32'd3 : 32'd0);
    endtask

    // One command: Enter rises, state checked after edge k+1, results after
    // edge k+2, then Enter stays high for 'hold' more cycles without refiring.
    task automatic applyStimulus(input string tag, input bit is_op,
                                 input logic [15:0] data, input int hold);
        @(negedge clk);
        bus.Enter  = 1'b1;
        bus.IsOp   = is_op;
        bus.DataIn = data;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput({tag, "_mid_state"}, 32'(bus.CurrentState),
                    m_err ? 32'd3 : (is_op ? 32'd2 : 32'd1));
        model_apply(is_op, data);
        @(posedge clk);
        #1;
        check_all(tag);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            check_all({tag, "_held"});
        end
        @(negedge clk);
        bus.Enter = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk);
        bus.Clear = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        bus.Clear = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        model_reset();
        reset      = 1'b1;
        bus.Clear  = 1'b0;
        bus.Enter  = 1'b1;
        bus.IsOp   = 1'b0;
        bus.DataIn = 16'd7;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");

        // Enter held high through reset release yields exactly one push.
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        model_apply(1'b0, 16'd7);
        check_all("enter_thru_reset");
        @(negedge clk);
        bus.Enter = 1'b0;
        do_clear("clr0");

        applyStimulus("p10", 1'b0, 16'd10, 20);
        applyStimulus("p5",  1'b0, 16'd5,  20);
        applyStimulus("add", 1'b1, 16'd0,  20);
        checkOutput("add_15", 32'(bus.ToDisplay), 32'd15);
        checkOutput("add_fl", 32'(bus.Flags), 32'h0);
        do_clear("clr1");

        applyStimulus("p50", 1'b0, 16'd50, 0);
        applyStimulus("p60", 1'b0, 16'd60, 0);
        applyStimulus("sub", 1'b1, 16'd1,  0);
        checkOutput("sub_val", 32'(bus.ToDisplay), 32'hFFF6);
        checkOutput("sub_fl",  32'(bus.Flags), 32'b1010);
        do_clear("clr2");

        applyStimulus("pmax", 1'b0, 16'h7FFF, 0);
        applyStimulus("p1",   1'b0, 16'h0001, 0);
        applyStimulus("addv", 1'b1, 16'd0,    0);
        checkOutput("addv_val", 32'(bus.ToDisplay), 32'h8000);
        checkOutput("addv_fl",  32'(bus.Flags), 32'b1001);
        applyStimulus("pm10", 1'b0, 16'hFFF6, 0);
        applyStimulus("pm5",  1'b0, 16'hFFFB, 0);
        applyStimulus("addc", 1'b1, 16'd0,    0);
        checkOutput("addc_val", 32'(bus.ToDisplay), 32'hFFF1);
        checkOutput("addc_fl",  32'(bus.Flags), 32'b1010);
        do_clear("clr3");

        for (int i = 0; i < 5; i++) applyStimulus("fill", 1'b0, 16'(i + 1), 0);
        checkOutput("ovf_state", 32'(bus.CurrentState), 32'd3);
        checkOutput("ovf_count", 32'(bus.Count), 32'd4);
        applyStimulus("ignored", 1'b0, 16'd99, 0);
        do_clear("clr4");

        applyStimulus("uflow", 1'b1, 16'd0, 0);
        checkOutput("uflow_err", 32'(bus.Error), 32'd1);
        do_clear("clr5");
        applyStimulus("p3",   1'b0, 16'd3, 0);
        applyStimulus("dup",  1'b1, 16'd4, 0);
        applyStimulus("swap", 1'b1, 16'd5, 0);
        applyStimulus("drop", 1'b1, 16'd6, 0);
        checkOutput("dsd_tod", 32'(bus.ToDisplay), 32'd3);
        checkOutput("dsd_cnt", 32'(bus.Count), 32'd1);
        do_clear("clr6");

        applyStimulus("p300", 1'b0, 16'd300,  0);
        applyStimulus("pm2",  1'b0, 16'hFFFE, 0);
        applyStimulus("op7",  1'b1, 16'd7,    0);
`ifdef RPN_MUL_EN
        checkOutput("mul_val", 32'(bus.ToDisplay), 32'hFDA8);
        checkOutput("mul_v",   32'(bus.Flags[0]), 32'd0);
`else
        checkOutput("op7_err", 32'(bus.Error), 32'd1);
        checkOutput("op7_cnt", 32'(bus.Count), 32'd2);
`endif
        do_clear("clr7");

        // Clear coincident with an Enter edge discards it; held Enter stays quiet.
        @(negedge clk);
        bus.Clear  = 1'b1;
        bus.Enter  = 1'b1;
        bus.IsOp   = 1'b0;
        bus.DataIn = 16'd9;
        @(negedge clk);
        bus.Clear = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_all("clr_enter");
        @(negedge clk);
        bus.Enter = 1'b0;
        @(negedge clk);

        // Asynchronous reset while the FSM sits in EXEC.
        applyStimulus("r1", 1'b0, 16'd1, 0);
        applyStimulus("r2", 1'b0, 16'd2, 0);
        @(negedge clk);
        bus.Enter  = 1'b1;
        bus.IsOp   = 1'b1;
        bus.DataIn = 16'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_exec_state", 32'(bus.CurrentState), 32'd2);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("rst_exec");
        @(negedge clk);
        bus.Enter = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 250; n++) begin
            if (m_err || ($urandom_range(0, 24) == 0)) begin
                do_clear("rnd_clr");
            end else if ($urandom_range(0, 1) == 1) begin
                applyStimulus("rnd_op", 1'b1, 16'($urandom_range(0, 7)),
                              $urandom_range(0, 2));
            end else begin
                applyStimulus("rnd_push", 1'b0, 16'($urandom),
                              $urandom_range(0, 2));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rpn_stack_calculator.md
# rpn_stack_calculator

Parametrised reverse-Polish calculator with an operand stack of configurable width and depth, four status flags and sticky error reporting. It accepts operands and opcodes through one debounced-level `Enter` strobe, executes stack operations in a small FSM and drives the top-of-stack value to the display path. It is the next generation of the board-level RPN calculator. The previous block handled exactly two operands and one operator; this one supports a real stack, more opcodes and error handling.

## Interface
- `WIDTH`, 16, operand/result width in bits (≥4)
- `DEPTH`, 4, stack entries (≥2)
- `clk` in 1: system clock, rising edge
- `reset` in 1: asynchronous, active-high reset
- `Clear` in 1: synchronous clear of stack, flags, error; has priority over `Enter`
- `Enter` in 1: level input, possibly held many cycles; only its rising edge is a command
- `IsOp` in 1: sampled with the `Enter` edge; 1 = `DataIn[2:0]` is an opcode, 0 = `DataIn` is an operand to push
- `DataIn` in WIDTH: operand or opcode
- `ToDisplay` out WIDTH: top of stack; 0 when the stack is empty
- `Flags` out 4: {N, Z, C, V} of the last arithmetic/logic result
- `Count` out $clog2(DEPTH+1): number of occupied entries
- `Error` out 1: sticky; set on overflow, underflow or illegal opcode
- `CurrentState` out 2: 0 IDLE, 1 PUSH, 2 EXEC, 3 ERROR

## Operation
- `Enter` is registered once; a command occurs when `Enter`=1 and the registered copy is 0. `IsOp` and `DataIn` are captured on that cycle.
- IDLE, operand command → PUSH:
  - PUSH writes `DataIn` to the new top and sets `Count`+1.
  - If `Count`==DEPTH, the stack is unchanged, `Error`=1 and the FSM goes to ERROR.
  - PUSH always returns to IDLE.
- IDLE, opcode command → EXEC.
- Operand order: B = top, A = next. Binary ops pop both entries and push A op B, so `Count`−1.
- Opcodes:
  - 0 ADD
  - 1 SUB (A−B)
  - 2 AND
  - 3 OR
  - 4 DUP: push copy of top
  - 5 SWAP
  - 6 DROP: pop
  - 7 MUL: see Configuration
- Flags are updated only by ADD/SUB/AND/OR/MUL:
  - N = result[WIDTH-1]
  - Z = result==0
  - ADD: C = unsigned carry-out; V = signed overflow
  - SUB: C = borrow (A<B unsigned); V = signed overflow
  - AND/OR: C=V=0
- DUP/SWAP/DROP leave `Flags` unchanged.
- Underflow (goes to ERROR, stack and flags unchanged):
  - binary op or SWAP with `Count`<2
  - DROP with `Count`==0
  - DUP with `Count`==0
- Overflow: DUP with `Count`==DEPTH goes to ERROR.
- ERROR holds until `Clear` or `reset`. All `Enter` edges in ERROR are ignored. `Stack`, `Count`, `ToDisplay` and `Flags` stay frozen.
- `Clear` in any state: `Count`=0, `Flags`=0, `Error`=0, state=IDLE on the next edge. A coincident `Enter` edge is discarded, and the `Enter` register still updates so a held `Enter` does not re-fire.
- Commands arriving while the FSM is in PUSH/EXEC cannot occur, because an edge needs at least 2 cycles between rises. If one does arrive, it is dropped.

## Timing
- Reset values:
  - `ToDisplay`=0, `Flags`=0, `Count`=0, `Error`=0, `CurrentState`=0
  - `Enter` register = 0. An `Enter` held high through reset release produces one command.
- Push: `Enter` rises at edge k (sampled). `CurrentState`=1 after edge k+1. `ToDisplay`/`Count` are updated and the FSM is back in IDLE after edge k+2.
- Op: `CurrentState`=2 after edge k+1. Result, `Flags`, `Count` and `Error` are visible after edge k+2.
- Asynchronous `reset` mid-PUSH/EXEC aborts the operation. The stack contents are don't-care, but `Count`=0.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Configuration
- `RPN_MUL_EN` defined: opcode 7 = MUL.
  - Result is the low WIDTH bits of the signed product A×B.
  - V=1 if the full signed product does not fit in WIDTH bits; C=0.
  - Same 2-cycle latency (single-cycle multiplier).
- Not defined: opcode 7 is illegal. It sets `Error` and goes to ERROR; stack and flags are unchanged.

## Test plan
- Reset, push 10, push 5, op 0: `ToDisplay`=15, `Count`=1, Flags=0000. `Enter` held 20 cycles yields exactly one command each.
- Push 50, push 60, op 1: `ToDisplay`=0xFFF6, N=1, C=1, V=0, Z=0.
- Push 0x7FFF, push 1, op 0: `ToDisplay`=0x8000, N=1, V=1, C=0. Then push −10 and −5 (0xFFF6, 0xFFFB), op 0: 0xFFF1, C=1, V=0.
- Five pushes with DEPTH=4: the fifth sets `Error`, `CurrentState`=3 and `Count`=4, and later `Enter` edges are ignored. `Clear` then gives `Count`=0, `Error`=0, IDLE.
- Empty stack: op 0 → `Error`=1. Push 3, DUP, SWAP, DROP → `Count`=1, `ToDisplay`=3, flags unchanged.
- Push 300, push −2, op 7: with `RPN_MUL_EN`, `ToDisplay`=0xFDA8 (−600), V=0. Without it, `Error`=1 and `Count`=2. Also assert `reset` mid-EXEC → all outputs return to their reset values immediately.
